// File: rtl/regfile_pkg.sv
// Shared defaults for the register file and its users (core, decode).
package regfile_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DEPTH  = 1 << RF_ADDR_W;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: reservation, release on writeback, flush, sticky write error.
// REGFILE_BYPASS_EN: a same-cycle writeback frees its register for reservation.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsv_en_i,
  input  logic [ADDR_W-1:0]     rsv_addr_i,
  input  logic                  wen_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic                  flush_i,
  output logic [(1<<ADDR_W)-1:0] pend_o,
  output logic                  rsv_ok_o,
  output logic                  wr_err_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d, pend_eff;
  logic             wr_err_q, wr_err_d;
  logic             w_act, r_act;

  always_comb begin
    w_act    = wen_i && !(ZERO_REG && (waddr_i == '0));
    pend_eff = pend_q;
`ifdef REGFILE_BYPASS_EN
    if (w_act) pend_eff[waddr_i] = 1'b0;
`endif
    rsv_ok_o = rsv_en_i && !pend_eff[rsv_addr_i];
    r_act    = rsv_ok_o && !(ZERO_REG && (rsv_addr_i == '0));

    // Flush first, then writeback release, then reservation: a reservation always wins.
    pend_d = flush_i ? '0 : pend_q;
    if (w_act) pend_d[waddr_i] = 1'b0;
    if (r_act) pend_d[rsv_addr_i] = 1'b1;

    wr_err_d = wr_err_q | (w_act & ~pend_q[waddr_i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign pend_o   = pend_q;
  assign wr_err_o = wr_err_q;
endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with pending-write scoreboard for RAW stall detection.
// REGFILE_BYPASS_EN: same-cycle writeback data and busy release forwarded to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              wr_err
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              w_act;

  assign w_act = wen && !(ZERO_REG && (waddr == '0));

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .wen_i      (wen),
    .waddr_i    (waddr),
    .flush_i    (flush),
    .pend_o     (pend),
    .rsv_ok_o   (rsv_ok),
    .wr_err_o   (wr_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_act) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = mem_q[raddr1];
    rbusy1 = pend[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (w_act && (raddr1 == waddr)) begin
      rdata1 = wdata;
      rbusy1 = 1'b0;
    end
`endif
    if (ZERO_REG && (raddr1 == '0)) begin
      rdata1 = '0;
      rbusy1 = 1'b0;
    end
  end

  always_comb begin
    rdata2 = mem_q[raddr2];
    rbusy2 = pend[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (w_act && (raddr2 == waddr)) begin
      rdata2 = wdata;
      rbusy2 = 1'b0;
    end
`endif
    if (ZERO_REG && (raddr2 == '0)) begin
      rdata2 = '0;
      rbusy2 = 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  reg_addr_t            raddr1, raddr2, rsv_addr, waddr;
  logic [RF_DATA_W-1:0] rdata1, rdata2, wdata;
  logic                 rbusy1, rbusy2, rsv_en, rsv_ok, wen, flush, wr_err;

  int n_vec = 0;
  int n_err = 0;

  regfile_sb #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .flush(flush), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and leave inputs settling 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; raddr1 = '0; raddr2 = '0; rsv_en = 1'b0; rsv_addr = '0;
    wen = 1'b0; waddr = '0; wdata = '0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;

    // Reset state
    check("rst_wr_err", wr_err, 0);
    for (int i = 0; i < 16; i++) begin
      raddr1 = reg_addr_t'(i);
      #1;
      check($sformatf("rst_busy_r%0d", i), rbusy1, 0);
      check($sformatf("rst_data_r%0d", i), rdata1, 0);
    end

    // r0 is hardwired zero: write ignored, no error, reserve accepted without effect
    wen = 1'b1; waddr = 4'd0; wdata = 32'hFF; raddr1 = 4'd0;
    rsv_en = 1'b1; rsv_addr = 4'd0;
    #1;
    check("r0_rsv_ok", rsv_ok, 1);
    check("r0_data_wcyc", rdata1, 0);
    tick();
    wen = 1'b0; rsv_en = 1'b0;
    #1;
    check("r0_data", rdata1, 0);
    check("r0_busy", rbusy1, 0);
    check("r0_wr_err", wr_err, 0);

    // Write 0x6D to unreserved r3
    raddr1 = 4'd3; wen = 1'b1; waddr = 4'd3; wdata = 32'h6D;
    #1;
    check("r3_data_wcyc", rdata1, BYP ? 32'h6D : 32'h0);
    tick();
    wen = 1'b0;
    #1;
    check("r3_data", rdata1, 32'h6D);
    check("r3_wr_err", wr_err, 1);

    // Reserve r5, retry refused, then write releases it
    rsv_en = 1'b1; rsv_addr = 4'd5; raddr2 = 4'd5;
    #1;
    check("r5_rsv_ok1", rsv_ok, 1);
    check("r5_busy_pre", rbusy2, 0);
    tick();
    check("r5_rsv_ok2", rsv_ok, 0);
    check("r5_busy", rbusy2, 1);
    rsv_en = 1'b0;
    wen = 1'b1; waddr = 4'd5; wdata = 32'h65;
    tick();
    wen = 1'b0;
    #1;
    check("r5_busy_after_wb", rbusy2, 0);
    check("r5_data", rdata2, 32'h65);

    // Same-cycle write and reserve of r7 (r7 initially free)
    raddr1 = 4'd7; wen = 1'b1; waddr = 4'd7; wdata = 32'h77;
    rsv_en = 1'b1; rsv_addr = 4'd7;
    #1;
    check("r7_rsv_ok", rsv_ok, 1);
    check("r7_data_wcyc", rdata1, BYP ? 32'h77 : 32'h0);
    check("r7_busy_wcyc", rbusy1, 0);
    tick();
    wen = 1'b0; rsv_en = 1'b0;
    #1;
    check("r7_data", rdata1, 32'h77);
    check("r7_busy", rbusy1, 1);

    // Same again while r7 is pending: only bypass frees it for the new reservation
    wen = 1'b1; waddr = 4'd7; wdata = 32'h78;
    rsv_en = 1'b1; rsv_addr = 4'd7;
    #1;
    check("r7p_rsv_ok", rsv_ok, BYP ? 1 : 0);
    tick();
    wen = 1'b0; rsv_en = 1'b0;
    #1;
    check("r7p_data", rdata1, 32'h78);
    check("r7p_busy", rbusy1, BYP ? 1 : 0);

    // Write to unreserved r9: data lands, error stays sticky
    raddr2 = 4'd9; wen = 1'b1; waddr = 4'd9; wdata = 32'h20;
    tick();
    wen = 1'b0;
    #1;
    check("r9_data", rdata2, 32'h20);
    check("r9_wr_err", wr_err, 1);
    tick();
    check("r9_wr_err_sticky", wr_err, 1);

    // Reserve r1, r2, r4, then flush together with reserve of r6
    rsv_en = 1'b1;
    rsv_addr = 4'd1; tick();
    rsv_addr = 4'd2; tick();
    rsv_addr = 4'd4; tick();
    rsv_addr = 4'd6; flush = 1'b1;
    #1;
    check("flush_rsv_ok", rsv_ok, 1);
    tick();
    rsv_en = 1'b0; flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      raddr1 = reg_addr_t'(i);
      #1;
      check($sformatf("flush_busy_r%0d", i), rbusy1, (i == 6) ? 1 : 0);
    end

    // Reset in the middle of a pending write and a reservation
    wen = 1'b1; waddr = 4'd6; wdata = 32'hAA;
    rsv_en = 1'b1; rsv_addr = 4'd8; rst = 1'b0;
    tick();
    rst = 1'b1; wen = 1'b0; rsv_addr = 4'd6;
    #1;
    check("rst2_wr_err", wr_err, 0);
    check("rst2_rsv_ok", rsv_ok, 1);
    rsv_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      raddr2 = reg_addr_t'(i);
      #1;
      check($sformatf("rst2_data_r%0d", i), rdata2, 0);
      check($sformatf("rst2_busy_r%0d", i), rbusy2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
